regfile_ctrl: RTL and testbench

Command sequencer for the 16×8 register file: after reset it zero-fills every register, then accepts one register-to-register command at a time over a valid/ready handshake. For each command it drives the two read selects, computes the result in a small ALU, writes back through the single write port, and reports result and flags. It sits between the instruction front end and the register file and is the only master of the file's ports.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_ctrl_alu.sv | 49 ++++
 rtl/regfile_ctrl.sv | 150 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file command sequencer.
package regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_LDI = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU: result, carry/borrow, zero flag and write-back qualifier.
module regfile_alu #(
  parameter int W = regfile_pkg::DATA_W
) (
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_imm,
  output logic [W-1:0] o_result,
  output logic         o_carry,
  output logic         o_zero,
  output logic         o_write
);
  import regfile_pkg::*;

  op_e        w_op;
  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_op   = op_e'(i_op);
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // The extra MSB of the widened difference is the borrow (a < b).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (w_op)
      OP_MOV: o_result = i_a;
      OP_ADD: begin
        o_result = w_sum[W-1:0];
        o_carry  = w_sum[W];
      end
      OP_SUB, OP_CMP: begin
        o_result = w_diff[W-1:0];
        o_carry  = w_diff[W];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_LDI: o_result = i_imm;
      default: o_result = '0;
    endcase
  end

  assign o_zero  = (o_result == '0);
  assign o_write = (w_op != OP_CMP);

endmodule

// File: rtl/regfile_ctrl.sv
// Command sequencer for the register file: zero-fill after reset, then one
// read-ALU-write command per two cycles over a valid/ready handshake.
module regfile_ctrl #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_sel_in,
  output logic [DATA_W-1:0] rf_in,
  output logic [ADDR_W-1:0] rf_sel_o1,
  output logic [ADDR_W-1:0] rf_sel_o2,
  input  logic [DATA_W-1:0] rf_o1,
  input  logic [DATA_W-1:0] rf_o2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              init_done
);
  import regfile_pkg::*;

  state_e            r_state;
  logic [ADDR_W-1:0] r_clear_cnt;
  logic              r_init_done;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_sel_o1;
  logic [ADDR_W-1:0] r_sel_o2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;
  logic              r_write;

  logic              w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_alu_write;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_WRITE);
  assign w_accept = cmd_valid && w_ready;

  regfile_alu #(.W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_a      (rf_o1),
    .i_b      (rf_o2),
    .i_imm    (r_imm),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero),
    .o_write  (w_alu_write)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clear_cnt <= '0;
      r_init_done <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clear_cnt <= r_clear_cnt + ADDR_W'(1);
          if (r_clear_cnt == {ADDR_W{1'b1}}) begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_result <= w_alu_result;
          r_zero   <= w_alu_zero;
          r_carry  <= w_alu_carry;
          r_write  <= w_alu_write;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_state <= cmd_valid ? S_READ : S_IDLE;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Command latch; read selects stay stable for the whole READ state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= 3'd0;
      r_rd     <= '0;
      r_sel_o1 <= '0;
      r_sel_o2 <= '0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_op     <= cmd_op;
      r_rd     <= cmd_rd;
      r_sel_o1 <= cmd_rs1;
      r_sel_o2 <= cmd_rs2;
      r_imm    <= cmd_imm;
    end
  end

  // Write port is shared between the zero-fill and command write-back.
  always_comb begin
    rf_we     = 1'b0;
    rf_sel_in = '0;
    rf_in     = '0;
    case (r_state)
      S_CLEAR: begin
        rf_we     = ~rst;
        rf_sel_in = r_clear_cnt;
      end
      S_WRITE: begin
        rf_we     = r_write;
        rf_sel_in = r_rd;
        rf_in     = r_result;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  assign cmd_ready = w_ready;
  assign rf_sel_o1 = r_sel_o1;
  assign rf_sel_o2 = r_sel_o2;
  assign rsp_valid = (r_state == S_WRITE);
  assign rsp_data  = r_result;
  assign rsp_zero  = r_zero;
  assign rsp_carry = r_carry;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: a behavioural register file model predicts
// each response, a negedge monitor compares whatever the DUT presents.
module tb_regfile_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_rd = 4'd0;
  logic [3:0] cmd_rs1 = 4'd0;
  logic [3:0] cmd_rs2 = 4'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic       rf_we;
  logic [3:0] rf_sel_in;
  logic [7:0] rf_in;
  logic [3:0] rf_sel_o1;
  logic [3:0] rf_sel_o2;
  logic [7:0] rf_o1;
  logic [7:0] rf_o2;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       init_done;

  typedef struct {
    int data;
    bit zero;
    bit carry;
    bit we;
    int rd;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cyc[$];
  int   ref_regs[16];
  logic [7:0] rf_mem [16];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t mon_e;

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_we(rf_we), .rf_sel_in(rf_sel_in), .rf_in(rf_in),
    .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2), .rf_o1(rf_o1), .rf_o2(rf_o2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .init_done(init_done)
  );

  // The register file the controller masters: combinational read, posedge write.
  assign rf_o1 = rf_mem[rf_sel_o1];
  assign rf_o2 = rf_mem[rf_sel_o2];
  always @(posedge clk) if (rf_we) rf_mem[rf_sel_in] <= rf_in;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input int rd, input int a, input int b, input int imm);
    exp_t e;
    int r;
    e.carry = 1'b0;
    case (op)
      0: r = a;
      1: begin r = a + b; e.carry = (r > 255); end
      2, 7: begin r = a - b; e.carry = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = imm;
      default: r = 0;
    endcase
    e.data = r & 255;
    e.zero = (e.data == 0);
    e.we   = (op != 7);
    e.rd   = rd;
    return e;
  endfunction

  // Monitor: every response pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_zero", rsp_zero, mon_e.zero);
        chk("rsp_carry", rsp_carry, mon_e.carry);
        chk("rsp_we", rf_we, mon_e.we);
        if (mon_e.we) begin
          chk("wr_idx", rf_sel_in, mon_e.rd);
          chk("wr_data", rf_in, mon_e.data);
        end
      end
    end
  end

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm, input bit keep);
    int n = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op  = op[2:0];
    cmd_rd  = rd[3:0];
    cmd_rs1 = rs1[3:0];
    cmd_rs2 = rs2[3:0];
    cmd_imm = imm[7:0];
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
    end else begin
      if (keep) begin
        e = model(op, rd, ref_regs[rs1], ref_regs[rs2], imm);
        exp_q.push_back(e);
        if (e.we) ref_regs[rd] = e.data;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic reset_and_init();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {rsp_zero, rsp_carry}, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_sel", {rf_sel_o1, rf_sel_o2, rf_sel_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clr_we", rf_we, 1);
      chk("clr_idx", rf_sel_in, i);
      chk("clr_data", rf_in, 0);
      chk("clr_ready", cmd_ready, 0);
      chk("clr_init_done", init_done, 0);
      @(negedge clk);
    end
    #1;
    chk("init_done", init_done, 1);
    chk("ready_cycle17", cmd_ready, 1);
    chk("idle_we", rf_we, 0);
    for (int r = 0; r < 16; r++) begin
      chk("zero_fill", rf_mem[r], 0);
      ref_regs[r] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 16; r++) rf_mem[r] = 8'($urandom_range(1, 255));
    reset_and_init();

    send(6, 1, 0, 0, 'h7F, 1'b1);
    send(6, 2, 0, 0, 'h01, 1'b1);
    send(1, 3, 1, 2, 0, 1'b1);
    send(1, 4, 3, 3, 0, 1'b1);
    send(2, 5, 2, 1, 0, 1'b1);
    send(7, 1, 1, 1, 0, 1'b1);
    idle();
    drain();
    chk("r1_after_cmp", rf_mem[1], 'h7F);
    chk("r3_add", rf_mem[3], 'h80);
    chk("r4_add_wrap", rf_mem[4], 'h00);
    chk("r5_sub", rf_mem[5], 'h82);

    rsp_cyc.delete();
    send(6, 6, 0, 0, 5, 1'b1);
    send(1, 6, 6, 6, 0, 1'b1);
    send(1, 6, 6, 6, 0, 1'b1);
    idle();
    drain();
    chk("chain_rsps", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("chain_gap1", rsp_cyc[1] - rsp_cyc[0], 2);
      chk("chain_gap2", rsp_cyc[2] - rsp_cyc[1], 2);
    end
    chk("r6_chain", rf_mem[6], 20);

    send(5, 7, 7, 7, 0, 1'b1);
    send(5, 7, 1, 1, 0, 1'b1);
    send(0, 8, 3, 0, 0, 1'b1);
    idle();
    drain();
    chk("r7_xor", rf_mem[7], 0);
    chk("r8_mov", rf_mem[8], 'h80);

    send(6, 9, 0, 0, 'hAA, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("abort_no_rsp", rsp_valid, 0);
    reset_and_init();

    for (int k = 0; k < 60; k++) begin
      send($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 255), 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    for (int r = 0; r < 16; r++) chk("final_reg", rf_mem[r], ref_regs[r]);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
